// File: rtl/xalu_ise_arb_if.sv
// Bundle of the requester, response and xalu_ise-facing signals for xalu_ise_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface xalu_ise_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req0_fn;
    logic [6:0]  req0_imm;
    logic [31:0] req0_in1;
    logic [31:0] req0_in2;
    logic [4:0]  req1_fn;
    logic [6:0]  req1_imm;
    logic [31:0] req1_in1;
    logic [31:0] req1_in2;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_err;
    logic [4:0]  x_fn;
    logic [6:0]  x_imm;
    logic [31:0] x_in1;
    logic [31:0] x_in2;
    logic        x_val;
    logic        x_oval;
    logic [31:0] x_out;
    logic        busy;

    modport slave (
        input  req_valid, req0_fn, req0_imm, req0_in1, req0_in2,
               req1_fn, req1_imm, req1_in1, req1_in2, rsp_ready, x_oval, x_out,
        output req_ready, rsp_valid, rsp_out, rsp_err,
               x_fn, x_imm, x_in1, x_in2, x_val, busy
    );

    modport master (
        output req_valid, req0_fn, req0_imm, req0_in1, req0_in2,
               req1_fn, req1_imm, req1_in1, req1_in2, rsp_ready, x_oval, x_out,
        input  req_ready, rsp_valid, rsp_out, rsp_err,
               x_fn, x_imm, x_in1, x_in2, x_val, busy
    );
endinterface

// File: rtl/xalu_ise_arb.sv
// Two-requester round-robin arbiter in front of a single xalu_ise datapath.
// Issues one op at a time, waits ISE_LAT cycles, returns result or error to the owner.
module xalu_ise_arb #(
    parameter int unsigned ISE_LAT = 0
) (
    input  logic           ise_clk,
    input  logic           ise_rst,
    xalu_ise_arb_if.slave  arb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] LAT_M1 = (ISE_LAT == 0) ? 3'd0 : 3'(ISE_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_prio;
    logic        r_gnt;
    logic [2:0]  r_cnt;
    logic [4:0]  r_fn;
    logic [6:0]  r_imm;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [31:0] r_rsp_out;
    logic        r_rsp_err;

    logic        w_gnt;
    logic        w_accept;
    logic        w_capture;
    logic        w_x_val;
    logic [1:0]  w_req_ready;
    logic [1:0]  w_rsp_valid;

    // Tie goes to r_prio; otherwise the single valid requester wins.
    assign w_gnt = (arb.req_valid == 2'b11) ? r_prio : arb.req_valid[1];

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_x_val     = 1'b0;
        w_req_ready = '0;
        w_rsp_valid = '0;
        case (r_state)
            S_IDLE: begin
                if (|arb.req_valid) begin
                    w_accept    = 1'b1;
                    w_req_ready = w_gnt ? 2'b10 : 2'b01;
                    w_next      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_x_val = 1'b1;
                if (ISE_LAT == 0) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAT_M1) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid = r_gnt ? 2'b10 : 2'b01;
                if (arb.rsp_ready[r_gnt]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_cnt     <= '0;
            r_fn      <= '0;
            r_imm     <= '0;
            r_in1     <= '0;
            r_in2     <= '0;
            r_rsp_out <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt  <= w_gnt;
                r_prio <= ~w_gnt;
                r_fn   <= w_gnt ? arb.req1_fn  : arb.req0_fn;
                r_imm  <= w_gnt ? arb.req1_imm : arb.req0_imm;
                r_in1  <= w_gnt ? arb.req1_in1 : arb.req0_in1;
                r_in2  <= w_gnt ? arb.req1_in2 : arb.req0_in2;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_capture) begin
                r_rsp_err <= ~arb.x_oval;
                r_rsp_out <= arb.x_oval ? arb.x_out : '0;
            end
        end
    end

    assign arb.req_ready = w_req_ready;
    assign arb.rsp_valid = w_rsp_valid;
    assign arb.rsp_out   = r_rsp_out;
    assign arb.rsp_err   = r_rsp_err;
    assign arb.x_fn      = r_fn;
    assign arb.x_imm     = r_imm;
    assign arb.x_in1     = r_in1;
    assign arb.x_in2     = r_in2;
    assign arb.x_val     = w_x_val;
    assign arb.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Directed bench for xalu_ise_arb: ISE_LAT=0 with a funnel-shift stub, ISE_LAT=2 with a delayed stub.
module tb_xalu_ise_arb;

    logic clk = 1'b0;
    logic ise_rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    xalu_ise_arb_if ifc0 ();
    xalu_ise_arb_if ifc1 ();

    xalu_ise_arb #(.ISE_LAT(0)) u_dut0 (.ise_clk(clk), .ise_rst(ise_rst), .arb(ifc0.slave));
    xalu_ise_arb #(.ISE_LAT(2)) u_dut1 (.ise_clk(clk), .ise_rst(ise_rst), .arb(ifc1.slave));

    // Combinational stub: fn 5'b00011 is fsr by 15 of {in1,in2}; anything else unrecognised.
    logic [63:0] w_cat;
    always_comb begin
        w_cat       = {ifc0.x_in1, ifc0.x_in2} >> 15;
        ifc0.x_oval = (ifc0.x_fn == 5'b00011);
        ifc0.x_out  = ifc0.x_oval ? w_cat[31:0] : 32'hBAD0BAD0;
    end

    // Two-cycle stub for the ISE_LAT=2 instance.
    logic r_d1, r_d2, stub_ok;
    always_ff @(posedge clk or posedge ise_rst) begin
        if (ise_rst) begin
            r_d1 <= 1'b0;
            r_d2 <= 1'b0;
        end else begin
            r_d1 <= ifc1.x_val;
            r_d2 <= r_d1;
        end
    end
    assign ifc1.x_oval = r_d2 & stub_ok;
    assign ifc1.x_out  = 32'hDEADBEEF;

    typedef struct {
        bit          r;
        logic [4:0]  fn;
        logic [6:0]  imm;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] out;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ise_rst = 1'b1;
        step();
        ise_rst = 1'b0;
        step();
    endtask

    task automatic op0(input vec_t v);
        logic [1:0] oh;
        oh = v.r ? 2'b10 : 2'b01;
        if (v.r) begin
            ifc0.req1_fn = v.fn; ifc0.req1_imm = v.imm; ifc0.req1_in1 = v.in1; ifc0.req1_in2 = v.in2;
            ifc0.req0_fn = 5'd3; ifc0.req0_imm = 7'h11; ifc0.req0_in1 = 32'hA5A5A5A5; ifc0.req0_in2 = 32'h5A5A5A5A;
        end else begin
            ifc0.req0_fn = v.fn; ifc0.req0_imm = v.imm; ifc0.req0_in1 = v.in1; ifc0.req0_in2 = v.in2;
            ifc0.req1_fn = 5'd3; ifc0.req1_imm = 7'h22; ifc0.req1_in1 = 32'hC3C3C3C3; ifc0.req1_in2 = 32'h3C3C3C3C;
        end
        ifc0.req_valid = oh;
        #1;
        chk("vec_req_ready", 32'(ifc0.req_ready), 32'(oh));
        step();
        ifc0.req_valid = 2'b00;
        chk("vec_x_val", 32'(ifc0.x_val), 32'd1);
        chk("vec_x_fn", 32'(ifc0.x_fn), 32'(v.fn));
        chk("vec_x_imm", 32'(ifc0.x_imm), 32'(v.imm));
        chk("vec_x_in1", ifc0.x_in1, v.in1);
        chk("vec_x_in2", ifc0.x_in2, v.in2);
        chk("vec_rsp_early", 32'(ifc0.rsp_valid), 32'd0);
        step();
        chk("vec_rsp_valid", 32'(ifc0.rsp_valid), 32'(oh));
        chk("vec_rsp_out", ifc0.rsp_out, v.out);
        chk("vec_rsp_err", 32'(ifc0.rsp_err), 32'(v.err));
        chk("vec_x_val_pulse", 32'(ifc0.x_val), 32'd0);
        chk("vec_ready_resp", 32'(ifc0.req_ready), 32'd0);
        ifc0.rsp_ready = oh;
        step();
        ifc0.rsp_ready = 2'b00;
        chk("vec_rsp_done", 32'(ifc0.rsp_valid), 32'd0);
        chk("vec_idle", 32'(ifc0.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, nr, w;
        logic last;

        vecs[0] = '{r: 1'b0, fn: 5'b00011, imm: 7'h00, in1: 32'h01234567, in2: 32'h89ABCDEF, out: 32'h8ACF1357, err: 1'b0};
        vecs[1] = '{r: 1'b1, fn: 5'b00000, imm: 7'h00, in1: 32'hDEADBEEF, in2: 32'h00000001, out: 32'h00000000, err: 1'b1};
        vecs[2] = '{r: 1'b1, fn: 5'b00011, imm: 7'h55, in1: 32'h00000000, in2: 32'h00008000, out: 32'h00000001, err: 1'b0};
        vecs[3] = '{r: 1'b0, fn: 5'b00011, imm: 7'h7F, in1: 32'hFFFFFFFF, in2: 32'h00000000, out: 32'hFFFE0000, err: 1'b0};
        vecs[4] = '{r: 1'b0, fn: 5'b11111, imm: 7'h01, in1: 32'h12345678, in2: 32'h9ABCDEF0, out: 32'h00000000, err: 1'b1};

        ifc0.req_valid = '0; ifc0.rsp_ready = '0;
        ifc0.req0_fn = '0; ifc0.req0_imm = '0; ifc0.req0_in1 = '0; ifc0.req0_in2 = '0;
        ifc0.req1_fn = '0; ifc0.req1_imm = '0; ifc0.req1_in1 = '0; ifc0.req1_in2 = '0;
        ifc1.req_valid = '0; ifc1.rsp_ready = '0;
        ifc1.req0_fn = '0; ifc1.req0_imm = '0; ifc1.req0_in1 = '0; ifc1.req0_in2 = '0;
        ifc1.req1_fn = '0; ifc1.req1_imm = '0; ifc1.req1_in1 = '0; ifc1.req1_in2 = '0;
        stub_ok = 1'b1;

        // Reset state
        #2;
        chk("rst_req_ready", 32'(ifc0.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifc0.rsp_valid), 32'd0);
        chk("rst_rsp_out", ifc0.rsp_out, 32'd0);
        chk("rst_rsp_err", 32'(ifc0.rsp_err), 32'd0);
        chk("rst_x_val", 32'(ifc0.x_val), 32'd0);
        chk("rst_x_in1", ifc0.x_in1, 32'd0);
        chk("rst_busy", 32'(ifc0.busy), 32'd0);
        chk("rst_busy1", 32'(ifc1.busy), 32'd0);
        step();
        ise_rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            op0(vecs[i]);
        end

        // Fairness: both requesting continuously, responses consumed at once
        do_reset();
        ifc0.req0_fn = 5'd3; ifc0.req0_in1 = 32'd0; ifc0.req0_in2 = 32'h00008000;
        ifc0.req1_fn = 5'd0; ifc0.req1_in1 = 32'h11111111; ifc0.req1_in2 = 32'h22222222;
        ifc0.rsp_ready = 2'b11;
        ifc0.req_valid = 2'b11;
        ng = 0; nr = 0; last = 1'b0;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            #1;
            if (ifc0.req_ready != 2'b00) begin
                chk("fair_onehot", 32'($onehot(ifc0.req_ready)), 32'd1);
                chk("fair_order", 32'(ifc0.req_ready[1]), 32'(ng % 2));
                last = ifc0.req_ready[1];
                ng++;
            end
            if (ifc0.rsp_valid != 2'b00) begin
                chk("fair_route", 32'(ifc0.rsp_valid), last ? 32'd2 : 32'd1);
                chk("fair_err", 32'(ifc0.rsp_err), 32'(last));
                nr++;
                if (nr == 4) ifc0.req_valid = 2'b00;
            end
            step();
        end
        chk("fair_grants", 32'(ng), 32'd4);
        chk("fair_rsps", 32'(nr), 32'd4);
        ifc0.rsp_ready = 2'b00;
        step();
        chk("fair_idle", 32'(ifc0.busy), 32'd0);

        // Response backpressure with r1 pending
        ifc0.req0_fn = 5'd3; ifc0.req0_in1 = 32'd0; ifc0.req0_in2 = 32'h00008000;
        ifc0.req1_fn = 5'd0;
        ifc0.req_valid = 2'b01;
        #1;
        chk("bp_grant0", 32'(ifc0.req_ready), 32'd1);
        step();
        ifc0.req_valid = 2'b10;
        ifc0.rsp_ready = 2'b10;
        step();
        chk("bp_rsp_valid", 32'(ifc0.rsp_valid), 32'd1);
        chk("bp_rsp_out", ifc0.rsp_out, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(ifc0.rsp_valid), 32'd1);
            chk("bp_hold_out", ifc0.rsp_out, 32'd1);
            chk("bp_hold_err", 32'(ifc0.rsp_err), 32'd0);
            chk("bp_no_grant", 32'(ifc0.req_ready), 32'd0);
        end
        ifc0.rsp_ready = 2'b01;
        #1;
        chk("bp_ready_in_resp", 32'(ifc0.req_ready), 32'd0);
        step();
        ifc0.rsp_ready = 2'b00;
        #1;
        chk("bp_r1_granted", 32'(ifc0.req_ready), 32'd2);
        chk("bp_rsp_cleared", 32'(ifc0.rsp_valid), 32'd0);
        step();
        ifc0.req_valid = 2'b00;
        step();
        chk("bp_r1_rsp", 32'(ifc0.rsp_valid), 32'd2);
        chk("bp_r1_err", 32'(ifc0.rsp_err), 32'd1);
        ifc0.rsp_ready = 2'b10;
        step();
        ifc0.rsp_ready = 2'b00;

        // Reset during ISSUE and during RESP
        do_reset();
        op0(vecs[0]);
        ifc0.req1_fn = 5'd3; ifc0.req1_in1 = 32'h13579BDF; ifc0.req1_in2 = 32'h00008000;
        ifc0.req_valid = 2'b10;
        #1;
        chk("rst5_grant1", 32'(ifc0.req_ready), 32'd2);
        step();
        ifc0.req_valid = 2'b00;
        chk("rst5_issue", 32'(ifc0.x_val), 32'd1);
        ise_rst = 1'b1;
        #1;
        chk("rst5_x_val", 32'(ifc0.x_val), 32'd0);
        chk("rst5_busy", 32'(ifc0.busy), 32'd0);
        chk("rst5_x_in1", ifc0.x_in1, 32'd0);
        chk("rst5_x_fn", 32'(ifc0.x_fn), 32'd0);
        chk("rst5_rsp_valid", 32'(ifc0.rsp_valid), 32'd0);
        step();
        ise_rst = 1'b0;
        ifc0.req0_fn = 5'd3; ifc0.req0_in1 = 32'd0; ifc0.req0_in2 = 32'h00008000;
        ifc0.req_valid = 2'b11;
        #1;
        chk("rst5_prio0", 32'(ifc0.req_ready), 32'd1);
        step();
        ifc0.req_valid = 2'b00;
        step();
        chk("rst5_resp", 32'(ifc0.rsp_valid), 32'd1);
        chk("rst5_resp_out", ifc0.rsp_out, 32'd1);
        ise_rst = 1'b1;
        #1;
        chk("rst5_resp_valid", 32'(ifc0.rsp_valid), 32'd0);
        chk("rst5_resp_out0", ifc0.rsp_out, 32'd0);
        chk("rst5_resp_busy", 32'(ifc0.busy), 32'd0);
        step();
        ise_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst5_no_stale", 32'(ifc0.rsp_valid), 32'd0);
        end

        // ISE_LAT=2 instance
        stub_ok = 1'b1;
        ifc1.req0_fn = 5'd3; ifc1.req0_in1 = 32'h0000_00AA; ifc1.req0_in2 = 32'h0000_0055;
        ifc1.req_valid = 2'b01;
        #1;
        chk("lat2_grant", 32'(ifc1.req_ready), 32'd1);
        step();
        ifc1.req_valid = 2'b00;
        chk("lat2_x_val", 32'(ifc1.x_val), 32'd1);
        step();
        chk("lat2_t2_valid", 32'(ifc1.rsp_valid), 32'd0);
        chk("lat2_t2_x_val", 32'(ifc1.x_val), 32'd0);
        step();
        chk("lat2_t3_valid", 32'(ifc1.rsp_valid), 32'd0);
        step();
        chk("lat2_t4_valid", 32'(ifc1.rsp_valid), 32'd1);
        chk("lat2_out", ifc1.rsp_out, 32'hDEADBEEF);
        chk("lat2_err", 32'(ifc1.rsp_err), 32'd0);
        ifc1.rsp_ready = 2'b01;
        step();
        ifc1.rsp_ready = 2'b00;
        chk("lat2_idle", 32'(ifc1.busy), 32'd0);

        stub_ok = 1'b0;
        ifc1.req1_fn = 5'd3;
        ifc1.req_valid = 2'b10;
        step();
        ifc1.req_valid = 2'b00;
        w = 0;
        while (ifc1.rsp_valid == 2'b00 && w < 10) begin
            step();
            w++;
        end
        chk("lat2_err_latency", 32'(w), 32'd3);
        chk("lat2_err_valid", 32'(ifc1.rsp_valid), 32'd2);
        chk("lat2_err_flag", 32'(ifc1.rsp_err), 32'd1);
        chk("lat2_err_out", ifc1.rsp_out, 32'd0);
        ifc1.rsp_ready = 2'b10;
        step();
        ifc1.rsp_ready = 2'b00;
        chk("lat2_err_idle", 32'(ifc1.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
